rs_exec_unit: RTL and testbench

- Execution stage between the reservation station and the result broadcast bus.
- Takes one ready-operand integer op per cycle from the reservation station and computes its result value and next PC.
- Drives the registered dest/value/next_pc triple onto the bus, which fans it out to issuer, reservation station, load/store buffer and reorder buffer.
- ROB IDs are 1-based; dest 0 on the bus means "no broadcast this cycle".

---
 rtl/rs_exec_unit.sv | 217 +++++++++++++++++++++
 tb/tb_rs_exec_unit.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_exec_unit.sv
// Execution stage between the reservation station and the result broadcast bus.
// Optional iterative multiplier enabled by defining RS_EXEC_MUL_EN.
module rs_exec_unit #(
  parameter int ROB_ID_WIDTH = 4,
  parameter int XLEN         = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush_from_ro_buffer,
  input  logic                    valid_from_rs_station,
  output logic                    ready_to_rs_station,
  input  logic [4:0]              op_from_rs_station,
  input  logic                    use_imm_from_rs_station,
  input  logic [XLEN-1:0]         rs1_from_rs_station,
  input  logic [XLEN-1:0]         rs2_from_rs_station,
  input  logic [XLEN-1:0]         imm_from_rs_station,
  input  logic [XLEN-1:0]         pc_from_rs_station,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_rs_station,
  output logic [ROB_ID_WIDTH-1:0] dest_to_rss_bus,
  output logic [XLEN-1:0]         value_to_rss_bus,
  output logic [XLEN-1:0]         next_pc_to_rss_bus,
  output logic                    state_dbg
);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_SLL   = 5'd2;
  localparam logic [4:0] OP_SLT   = 5'd3;
  localparam logic [4:0] OP_SLTU  = 5'd4;
  localparam logic [4:0] OP_XOR   = 5'd5;
  localparam logic [4:0] OP_SRL   = 5'd6;
  localparam logic [4:0] OP_SRA   = 5'd7;
  localparam logic [4:0] OP_OR    = 5'd8;
  localparam logic [4:0] OP_AND   = 5'd9;
  localparam logic [4:0] OP_BEQ   = 5'd10;
  localparam logic [4:0] OP_BNE   = 5'd11;
  localparam logic [4:0] OP_BLT   = 5'd12;
  localparam logic [4:0] OP_BGE   = 5'd13;
  localparam logic [4:0] OP_BLTU  = 5'd14;
  localparam logic [4:0] OP_BGEU  = 5'd15;
  localparam logic [4:0] OP_JAL   = 5'd16;
  localparam logic [4:0] OP_JALR  = 5'd17;
  localparam logic [4:0] OP_LUI   = 5'd18;
  localparam logic [4:0] OP_AUIPC = 5'd19;
  localparam logic [4:0] OP_MUL   = 5'd20;

`ifdef RS_EXEC_MUL_EN
  typedef enum logic {IDLE = 1'b0, MUL_BUSY = 1'b1} state_t;
`else
  typedef enum logic {IDLE = 1'b0} state_t;
`endif

  state_t state;
  assign state_dbg = state;

  logic [XLEN-1:0] operand_b;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] jalr_target;
  logic [4:0]      shamt;
  logic            taken;
  logic [XLEN-1:0] alu_value;
  logic [XLEN-1:0] alu_next_pc;
  logic            start_mul;

  assign operand_b   = use_imm_from_rs_station ? imm_from_rs_station : rs2_from_rs_station;
  assign pc_plus4    = pc_from_rs_station + XLEN'(4);
  assign pc_plus_imm = pc_from_rs_station + imm_from_rs_station;
  assign jalr_target = rs1_from_rs_station + imm_from_rs_station;
  assign shamt       = operand_b[4:0];

  // Branch conditions always look at rs2, never at the immediate.
  always_comb begin
    taken = 1'b0;
    case (op_from_rs_station)
      OP_BEQ:  taken = (rs1_from_rs_station == rs2_from_rs_station);
      OP_BNE:  taken = (rs1_from_rs_station != rs2_from_rs_station);
      OP_BLT:  taken = ($signed(rs1_from_rs_station) <  $signed(rs2_from_rs_station));
      OP_BGE:  taken = ($signed(rs1_from_rs_station) >= $signed(rs2_from_rs_station));
      OP_BLTU: taken = (rs1_from_rs_station <  rs2_from_rs_station);
      OP_BGEU: taken = (rs1_from_rs_station >= rs2_from_rs_station);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    alu_value   = '0;
    alu_next_pc = pc_plus4;
    case (op_from_rs_station)
      OP_ADD:  alu_value = rs1_from_rs_station + operand_b;
      OP_SUB:  alu_value = rs1_from_rs_station - operand_b;
      OP_SLL:  alu_value = rs1_from_rs_station << shamt;
      OP_SLT:  alu_value = {{(XLEN-1){1'b0}}, ($signed(rs1_from_rs_station) < $signed(operand_b))};
      OP_SLTU: alu_value = {{(XLEN-1){1'b0}}, (rs1_from_rs_station < operand_b)};
      OP_XOR:  alu_value = rs1_from_rs_station ^ operand_b;
      OP_SRL:  alu_value = rs1_from_rs_station >> shamt;
      OP_SRA:  alu_value = $signed(rs1_from_rs_station) >>> shamt;
      OP_OR:   alu_value = rs1_from_rs_station | operand_b;
      OP_AND:  alu_value = rs1_from_rs_station & operand_b;
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        alu_value   = {{(XLEN-1){1'b0}}, taken};
        alu_next_pc = taken ? pc_plus_imm : pc_plus4;
      end
      OP_JAL: begin
        alu_value   = pc_plus4;
        alu_next_pc = pc_plus_imm;
      end
      OP_JALR: begin
        alu_value   = pc_plus4;
        alu_next_pc = {jalr_target[XLEN-1:1], 1'b0};
      end
      OP_LUI:   alu_value = imm_from_rs_station;
      OP_AUIPC: alu_value = pc_plus_imm;
      OP_MUL:   alu_value = '0;
      default:  alu_value = rs1_from_rs_station + operand_b;
    endcase
  end

`ifdef RS_EXEC_MUL_EN
  logic [XLEN-1:0]         mul_acc;
  logic [XLEN-1:0]         mul_mcand;
  logic [XLEN-1:0]         mul_mplier;
  logic [4:0]              mul_cnt;
  logic [ROB_ID_WIDTH-1:0] mul_dest;
  logic [XLEN-1:0]         mul_next_pc;
  logic [XLEN-1:0]         mul_acc_next;

  assign start_mul    = valid_from_rs_station && ready_to_rs_station &&
                        (op_from_rs_station == OP_MUL);
  assign mul_acc_next = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
`else
  assign start_mul = 1'b0;
`endif

  // Handshake: an op transfers on a rising edge where valid, ready and rdy are
  // all high and no flush is present; its result is on the bus for the next
  // cycle only. ready is registered so it never depends on valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      ready_to_rs_station <= 1'b1;
      dest_to_rss_bus     <= '0;
      value_to_rss_bus    <= '0;
      next_pc_to_rss_bus  <= '0;
`ifdef RS_EXEC_MUL_EN
      mul_acc     <= '0;
      mul_mcand   <= '0;
      mul_mplier  <= '0;
      mul_cnt     <= '0;
      mul_dest    <= '0;
      mul_next_pc <= '0;
`endif
    end else if (rdy) begin
      if (flush_from_ro_buffer) begin
        state               <= IDLE;
        ready_to_rs_station <= 1'b1;
        dest_to_rss_bus     <= '0;
        value_to_rss_bus    <= '0;
        next_pc_to_rss_bus  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (valid_from_rs_station && ready_to_rs_station && !start_mul) begin
              dest_to_rss_bus    <= dest_from_rs_station;
              value_to_rss_bus   <= alu_value;
              next_pc_to_rss_bus <= alu_next_pc;
            end else begin
              dest_to_rss_bus    <= '0;
              value_to_rss_bus   <= '0;
              next_pc_to_rss_bus <= '0;
            end
`ifdef RS_EXEC_MUL_EN
            if (start_mul) begin
              state               <= MUL_BUSY;
              ready_to_rs_station <= 1'b0;
              mul_acc             <= '0;
              mul_mcand           <= rs1_from_rs_station;
              mul_mplier          <= operand_b;
              mul_cnt             <= '0;
              mul_dest            <= dest_from_rs_station;
              mul_next_pc         <= pc_plus4;
            end
`endif
          end
`ifdef RS_EXEC_MUL_EN
          MUL_BUSY: begin
            // One multiplier bit per cycle; the 32nd step drives the bus directly.
            mul_acc            <= mul_acc_next;
            mul_mcand          <= mul_mcand << 1;
            mul_mplier         <= mul_mplier >> 1;
            mul_cnt            <= mul_cnt + 5'd1;
            dest_to_rss_bus    <= '0;
            value_to_rss_bus   <= '0;
            next_pc_to_rss_bus <= '0;
            if (mul_cnt == 5'd31) begin
              state               <= IDLE;
              ready_to_rs_station <= 1'b1;
              dest_to_rss_bus     <= mul_dest;
              value_to_rss_bus    <= mul_acc_next;
              next_pc_to_rss_bus  <= mul_next_pc;
            end
          end
`endif
          default: begin
            state               <= IDLE;
            ready_to_rs_station <= 1'b1;
            dest_to_rss_bus     <= '0;
            value_to_rss_bus    <= '0;
            next_pc_to_rss_bus  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rs_exec_unit.sv
// Self-checking bench for rs_exec_unit: directed scenarios plus a randomized
// run scored against a behavioural model; honours RS_EXEC_MUL_EN.
module tb_rs_exec_unit;

  localparam int W = 68;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        valid;
  logic        ready;
  logic [4:0]  op;
  logic        use_imm;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] imm;
  logic [31:0] pc;
  logic [3:0]  dest_in;
  logic [3:0]  dest;
  logic [31:0] value;
  logic [31:0] next_pc;
  logic        state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  rs_exec_unit #(.ROB_ID_WIDTH(4), .XLEN(32)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .rdy                     (rdy),
    .flush_from_ro_buffer    (flush),
    .valid_from_rs_station   (valid),
    .ready_to_rs_station     (ready),
    .op_from_rs_station      (op),
    .use_imm_from_rs_station (use_imm),
    .rs1_from_rs_station     (rs1),
    .rs2_from_rs_station     (rs2),
    .imm_from_rs_station     (imm),
    .pc_from_rs_station      (pc),
    .dest_from_rs_station    (dest_in),
    .dest_to_rss_bus         (dest),
    .value_to_rss_bus        (value),
    .next_pc_to_rss_bus      (next_pc),
    .state_dbg               (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] bus;
  assign bus = {dest, value, next_pc};

  // Behavioural reference: {dest, value, next_pc} of a completing op.
  function automatic logic [W-1:0] model(input logic [4:0] o, input logic ui,
                                         input logic [31:0] a, input logic [31:0] r2,
                                         input logic [31:0] im, input logic [31:0] p,
                                         input logic [3:0] d);
    logic [31:0] b, v, np;
    logic        t;
    b  = ui ? im : r2;
    v  = 32'd0;
    np = p + 32'd4;
    t  = 1'b0;
    case (o)
      5'd1:  v = a - b;
      5'd2:  v = a << b[4:0];
      5'd3:  v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd4:  v = (a < b) ? 32'd1 : 32'd0;
      5'd5:  v = a ^ b;
      5'd6:  v = a >> b[4:0];
      5'd7:  v = $signed(a) >>> b[4:0];
      5'd8:  v = a | b;
      5'd9:  v = a & b;
      5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15: begin
        if (o == 5'd10) t = (a == r2);
        if (o == 5'd11) t = (a != r2);
        if (o == 5'd12) t = ($signed(a) < $signed(r2));
        if (o == 5'd13) t = !($signed(a) < $signed(r2));
        if (o == 5'd14) t = (a < r2);
        if (o == 5'd15) t = !(a < r2);
        v  = t ? 32'd1 : 32'd0;
        np = t ? p + im : p + 32'd4;
      end
      5'd16: begin v = p + 32'd4; np = p + im; end
      5'd17: begin v = p + 32'd4; np = (a + im) & 32'hFFFF_FFFE; end
      5'd18: v = im;
      5'd19: v = p + im;
`ifdef RS_EXEC_MUL_EN
      5'd20: v = a * b;
`else
      5'd20: v = 32'd0;
`endif
      default: v = a + b;
    endcase
    return {d, v, np};
  endfunction

  // driver tasks
  task automatic drive(input logic [4:0] o, input logic ui, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im,
                       input logic [31:0] p, input logic [3:0] d);
    valid = 1'b1; op = o; use_imm = ui; rs1 = a; rs2 = b; imm = im; pc = p; dest_in = d;
  endtask

  task automatic idle_inputs();
    valid = 1'b0; flush = 1'b0; rdy = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    drive(5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd1);
    valid = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({ready, state_dbg, bus} !== {1'b1, 1'b0, {W{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_state: got ready=%b st=%b bus=%h want ready=1 st=0 bus=0",
               ready, state_dbg, bus);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midstream();
    drive(5'd0, 1'b0, 32'd7, 32'd8, 32'd0, 32'h500, 4'd9);
    @(negedge clk);
    n_checks++;
    if (bus !== {4'd9, 32'd15, 32'h504}) begin
      n_fail++; $display("FAIL midstream_pre: got %h want %h", bus, {4'd9, 32'd15, 32'h504});
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({ready, bus} !== {1'b1, {W{1'b0}}}) begin
      n_fail++; $display("FAIL midstream_async: got ready=%b bus=%h want ready=1 bus=0", ready, bus);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (bus !== {W{1'b0}}) begin
      n_fail++; $display("FAIL midstream_after: got %h want 0", bus);
    end
  endtask

  task automatic test_add();
    drive(5'd0, 1'b1, 32'hFFFF_FFFF, 32'h55, 32'd2, 32'h100, 4'd3);
    @(negedge clk);
    valid = 1'b0;
    n_checks++;
    if (bus !== {4'd3, 32'd1, 32'h104}) begin
      n_fail++; $display("FAIL add: got %h want %h", bus, {4'd3, 32'd1, 32'h104});
    end
    @(negedge clk);
    n_checks++;
    if (bus !== {W{1'b0}}) begin
      n_fail++; $display("FAIL add_idle: got %h want 0", bus);
    end
  endtask

  task automatic test_branch();
    drive(5'd12, 1'b1, 32'hFFFF_FFFE, 32'd1, 32'h20, 32'h40, 4'd7);
    @(negedge clk);
    drive(5'd14, 1'b1, 32'hFFFF_FFFE, 32'd1, 32'h20, 32'h40, 4'd8);
    n_checks++;
    if (bus !== {4'd7, 32'd1, 32'h60}) begin
      n_fail++; $display("FAIL blt: got %h want %h", bus, {4'd7, 32'd1, 32'h60});
    end
    @(negedge clk);
    valid = 1'b0;
    n_checks++;
    if (bus !== {4'd8, 32'd0, 32'h44}) begin
      n_fail++; $display("FAIL bltu: got %h want %h", bus, {4'd8, 32'd0, 32'h44});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    drive(5'd17, 1'b0, 32'h1001, 32'd0, 32'd4, 32'h200, 4'd5);
    @(negedge clk);
    drive(5'd7, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 32'h300, 4'd6);
    n_checks++;
    if (bus !== {4'd5, 32'h204, 32'h1004}) begin
      n_fail++; $display("FAIL jalr: got %h want %h", bus, {4'd5, 32'h204, 32'h1004});
    end
    @(negedge clk);
    valid = 1'b0;
    n_checks++;
    if (bus !== {4'd6, 32'hF800_0000, 32'h304}) begin
      n_fail++; $display("FAIL sra_b2b: got %h want %h", bus, {4'd6, 32'hF800_0000, 32'h304});
    end
    @(negedge clk);
    n_checks++;
    if (bus !== {W{1'b0}}) begin
      n_fail++; $display("FAIL b2b_idle: got %h want 0", bus);
    end
  endtask

  task automatic test_flush();
    drive(5'd5, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0, 32'h80, 4'd2);
    @(negedge clk);
    drive(5'd0, 1'b0, 32'd1, 32'd1, 32'd0, 32'h90, 4'd4);
    flush = 1'b1;
    n_checks++;
    if (bus !== {4'd2, 32'hFF00, 32'h84}) begin
      n_fail++; $display("FAIL flush_first: got %h want %h", bus, {4'd2, 32'hFF00, 32'h84});
    end
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if ({ready, bus} !== {1'b1, {W{1'b0}}}) begin
      n_fail++; $display("FAIL flush_kill: got ready=%b bus=%h want ready=1 bus=0", ready, bus);
    end
    @(negedge clk);
    n_checks++;
    if (bus !== {W{1'b0}}) begin
      n_fail++; $display("FAIL flush_discard: got %h want 0", bus);
    end
  endtask

  task automatic test_rdy_hold();
    drive(5'd18, 1'b1, 32'd0, 32'd0, 32'hABCD_E000, 32'h600, 4'd11);
    @(negedge clk);
    drive(5'd0, 1'b0, 32'd3, 32'd4, 32'd0, 32'h700, 4'd12);
    rdy = 1'b0;
    flush = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (bus !== {4'd11, 32'hABCD_E000, 32'h604}) begin
        n_fail++; $display("FAIL rdy_hold_%0d: got %h want %h", k, bus, {4'd11, 32'hABCD_E000, 32'h604});
      end
      @(negedge clk);
    end
    n_checks++;
    if (bus !== {4'd11, 32'hABCD_E000, 32'h604}) begin
      n_fail++; $display("FAIL rdy_hold_end: got %h want %h", bus, {4'd11, 32'hABCD_E000, 32'h604});
    end
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (bus !== {W{1'b0}}) begin
      n_fail++; $display("FAIL rdy_release: got %h want 0", bus);
    end
  endtask

`ifdef RS_EXEC_MUL_EN
  task automatic test_mul();
    logic [31:0] a, b;
    logic        stuck;
    drive(5'd20, 1'b0, 32'h10001, 32'h10001, 32'd0, 32'h800, 4'd13);
    @(negedge clk);
    drive(5'd0, 1'b0, 32'd5, 32'd6, 32'd0, 32'h900, 4'd14);
    for (int k = 1; k <= 32; k++) begin
      n_checks++;
      if ({ready, state_dbg, dest} !== {1'b0, 1'b1, 4'd0}) begin
        n_fail++; $display("FAIL mul_busy_%0d: got ready=%b st=%b dest=%h want 0,1,0",
                           k, ready, state_dbg, dest);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({ready, bus} !== {1'b1, 4'd13, 32'h0002_0001, 32'h804}) begin
      n_fail++; $display("FAIL mul_result: got ready=%b bus=%h want ready=1 bus=%h",
                         ready, bus, {4'd13, 32'h0002_0001, 32'h804});
    end
    @(negedge clk);
    valid = 1'b0;
    n_checks++;
    if (bus !== {4'd14, 32'd11, 32'h904}) begin
      n_fail++; $display("FAIL mul_next_accept: got %h want %h", bus, {4'd14, 32'd11, 32'h904});
    end
    // flush during the multiply
    a = $urandom; b = $urandom;
    drive(5'd20, 1'b0, a, b, 32'd0, 32'hA00, 4'd15);
    @(negedge clk);
    valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if ({ready, state_dbg, bus} !== {1'b1, 1'b0, {W{1'b0}}}) begin
      n_fail++; $display("FAIL mul_flush: got ready=%b st=%b bus=%h want 1,0,0", ready, state_dbg, bus);
    end
    stuck = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus !== {W{1'b0}}) stuck = 1'b1;
    end
    n_checks++;
    if (stuck !== 1'b0) begin
      n_fail++; $display("FAIL mul_flush_silent: got broadcast=%b want 0", stuck);
    end
    // random operands with immediate as B
    a = $urandom; b = $urandom;
    drive(5'd20, 1'b1, a, 32'd0, b, 32'hB00, 4'd1);
    @(negedge clk);
    valid = 1'b0;
    repeat (32) @(negedge clk);
    n_checks++;
    if (bus !== model(5'd20, 1'b1, a, 32'd0, b, 32'hB00, 4'd1)) begin
      n_fail++; $display("FAIL mul_random: got %h want %h", bus, model(5'd20, 1'b1, a, 32'd0, b, 32'hB00, 4'd1));
    end
    @(negedge clk);
  endtask
`else
  task automatic test_mul();
    drive(5'd20, 1'b0, 32'h10001, 32'h10001, 32'd0, 32'h800, 4'd13);
    @(negedge clk);
    valid = 1'b0;
    n_checks++;
    if ({ready, bus} !== {1'b1, 4'd13, 32'd0, 32'h804}) begin
      n_fail++; $display("FAIL mul_single: got ready=%b bus=%h want ready=1 bus=%h",
                         ready, bus, {4'd13, 32'd0, 32'h804});
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_random();
    logic [W-1:0] last, e, got;
    idle_inputs();
    @(negedge clk);
    last = '0;
    for (int i = 0; i < 400; i++) begin
      drive(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom,
            ($urandom_range(0, 3) == 0) ? rs1 : $urandom, $urandom, $urandom & 32'hFFFF_FFFC,
            4'($urandom_range(1, 15)));
`ifdef RS_EXEC_MUL_EN
      if (op == 5'd20) op = 5'd0;
`endif
      if ($urandom_range(0, 3) == 0) rs2 = rs1;
      valid = ($urandom_range(0, 3) != 0);
      rdy   = ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 15) == 0);
      if (!rdy)       e = last;
      else if (flush) e = '0;
      else if (valid) e = model(op, use_imm, rs1, rs2, imm, pc, dest_in);
      else            e = '0;
      last = e;
      exp_q.push_back(e);
      @(negedge clk);
      got = exp_q.pop_front();
      n_checks++;
      if ({ready, bus} !== {1'b1, got}) begin
        n_fail++; $display("FAIL random_%0d op=%0d: got ready=%b bus=%h want ready=1 bus=%h",
                           i, op, ready, bus, got);
      end
    end
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; valid = 1'b0;
    op = '0; use_imm = 1'b0; rs1 = '0; rs2 = '0; imm = '0; pc = '0; dest_in = '0;
    test_reset();
    test_add();
    test_branch();
    test_back_to_back();
    test_flush();
    test_rdy_hold();
    test_mul();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
